// File: rtl/psg_pkg.sv
// Shared PSG constants and types for the PDM output stage.
package psg_pkg;

    localparam int unsigned PSG_VALUE_BITS = 8;
    localparam int unsigned PSG_CHANNELS   = 4;

    typedef logic [PSG_VALUE_BITS-1:0] pdm_value_t;

endpackage

// File: rtl/pdm_slot_adder.sv
// Shared sigma-delta adder: zero-extended sum of accumulator and channel value.
module pdm_slot_adder
    import psg_pkg::*;
#(
    parameter int unsigned VALUE_BITS = PSG_VALUE_BITS
) (
    input  logic [VALUE_BITS-1:0] acc,
    input  logic [VALUE_BITS-1:0] value,
    output logic [VALUE_BITS:0]   sum
);

    // Carry-preserving add; bit VALUE_BITS is the PDM output bit
    always_comb begin
        sum = {1'b0, acc} + {1'b0, value};
    end

endmodule

// File: rtl/pdm_scheduler.sv
// Time-multiplexed first-order PDM engine: one shared adder, round-robin slots,
// shadow registers committed at frame boundaries.
module pdm_scheduler
    import psg_pkg::*;
#(
    parameter  int unsigned VALUE_BITS = PSG_VALUE_BITS,
    parameter  int unsigned CHANNELS   = PSG_CHANNELS,
    localparam int unsigned CW         = $clog2(CHANNELS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  wr_valid,
    input  logic [CW-1:0]         wr_channel,
    input  logic [VALUE_BITS-1:0] wr_value,
    output logic                  wr_ready,
    output logic                  wr_error,
    output logic [CW-1:0]         slot,
    output logic                  frame_start,
    output logic [CHANNELS-1:0]   pdm_out
);

    localparam int unsigned AW            = VALUE_BITS + 1;
    localparam logic [CW-1:0] LAST_SLOT   = CW'(CHANNELS - 1);
    localparam logic [CW:0]   CHANNEL_LIM = (CW+1)'(CHANNELS);

    logic [CW-1:0]         slot_q;
    logic [AW-1:0]         acc_q    [CHANNELS];
    logic [VALUE_BITS-1:0] shadow_q [CHANNELS];
    logic [VALUE_BITS-1:0] active_q [CHANNELS];
    logic                  wr_error_q;

    logic                  wr_accept_c;
    logic                  wr_in_range_c;
    logic                  shadow_we_c;
    logic                  commit_c;
    logic [CW-1:0]         slot_next_c;
    logic [VALUE_BITS-1:0] acc_low_c;
    logic [VALUE_BITS-1:0] active_sel_c;
    logic [AW-1:0]         sum_c;

    // Write handshake, range check, commit and slot-advance decode
    always_comb begin
        wr_accept_c   = wr_valid && wr_ready;
        wr_in_range_c = {1'b0, wr_channel} < CHANNEL_LIM;
        shadow_we_c   = wr_accept_c && wr_in_range_c;
        commit_c      = enable && (slot_q == LAST_SLOT);
        slot_next_c   = (slot_q == LAST_SLOT) ? '0 : slot_q + CW'(1);
        acc_low_c     = acc_q[slot_q][VALUE_BITS-1:0];
        active_sel_c  = active_q[slot_q];
    end

    pdm_slot_adder #(
        .VALUE_BITS (VALUE_BITS)
    ) u_slot_adder (
        .acc   (acc_low_c),
        .value (active_sel_c),
        .sum   (sum_c)
    );

    // Round-robin slot counter, frozen while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q <= '0;
        end else if (enable) begin
            slot_q <= slot_next_c;
        end
    end

    // Accumulator of the current slot takes the new sum including carry
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                acc_q[c] <= '0;
            end
        end else if (enable) begin
            acc_q[slot_q] <= sum_c;
        end
    end

    // Host writes land in shadow registers regardless of enable
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                shadow_q[c] <= '0;
            end
        end else if (shadow_we_c) begin
            shadow_q[wr_channel] <= wr_value;
        end
    end

    // Frame-boundary commit; a same-cycle write bypasses its shadow register
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                active_q[c] <= '0;
            end
        end else if (commit_c) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                active_q[c] <= (shadow_we_c && (wr_channel == CW'(c))) ? wr_value : shadow_q[c];
            end
        end
    end

    // One-cycle error pulse for an accepted write to a nonexistent channel
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_error_q <= 1'b0;
        end else begin
            wr_error_q <= wr_accept_c && !wr_in_range_c;
        end
    end

    // PDM bits are the stored carries, so they move only when their slot runs
    always_comb begin
        pdm_out = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            pdm_out[c] = acc_q[c][VALUE_BITS];
        end
    end

    // Status outputs
    always_comb begin
        wr_ready    = !reset;
        wr_error    = wr_error_q;
        slot        = slot_q;
        frame_start = (slot_q == '0) && enable && !reset;
    end

endmodule

// File: tb/tb_pdm_scheduler.sv
// Randomized and directed bench for pdm_scheduler against a frame-level reference model.
module tb_pdm_scheduler;
    import psg_pkg::*;

    localparam int unsigned VB  = PSG_VALUE_BITS;
    localparam int unsigned CH  = 5;
    localparam int unsigned CW  = $clog2(CH);
    localparam int unsigned MOD = 1 << VB;

    logic          clk;
    logic          reset;
    logic          enable;
    logic          wr_valid;
    logic [CW-1:0] wr_channel;
    pdm_value_t    wr_value;
    logic          wr_ready;
    logic          wr_error;
    logic [CW-1:0] slot;
    logic          frame_start;
    logic [CH-1:0] pdm_out;

    int n_cmp;
    int n_bad;
    bit cmp_en;

    pdm_scheduler #(
        .VALUE_BITS (VB),
        .CHANNELS   (CH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .wr_valid    (wr_valid),
        .wr_channel  (wr_channel),
        .wr_value    (wr_value),
        .wr_ready    (wr_ready),
        .wr_error    (wr_error),
        .slot        (slot),
        .frame_start (frame_start),
        .pdm_out     (pdm_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: each channel keeps a phase modulo 2^VB; a frame adds the
    // committed value and emits 1 when the phase wraps.
    int unsigned m_slot;
    int unsigned m_phase  [CH];
    int unsigned m_shadow [CH];
    int unsigned m_active [CH];
    logic [CH-1:0] m_pdm;
    logic          m_err;
    int unsigned   m_total;

    always @(posedge clk) begin
        if (reset) begin
            m_slot = 0;
            m_pdm  = '0;
            m_err  = 1'b0;
            for (int c = 0; c < CH; c++) begin
                m_phase[c]  = 0;
                m_shadow[c] = 0;
                m_active[c] = 0;
            end
        end else begin
            m_err = wr_valid && (int'(wr_channel) >= CH);
            if (wr_valid && int'(wr_channel) < CH) m_shadow[int'(wr_channel)] = int'(wr_value);
            if (enable) begin
                m_total          = m_phase[m_slot] + m_active[m_slot];
                m_pdm[m_slot]    = (m_total >= MOD);
                m_phase[m_slot]  = m_total % MOD;
                if (m_slot == CH - 1) begin
                    for (int c = 0; c < CH; c++) m_active[c] = m_shadow[c];
                    m_slot = 0;
                end else begin
                    m_slot = m_slot + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("slot", 32'(slot), 32'(m_slot));
            check("pdm_out", 32'(pdm_out), 32'(m_pdm));
            check("wr_ready", 32'(wr_ready), 32'(!reset));
            check("wr_error", 32'(wr_error), 32'(m_err));
            check("frame_start", 32'(frame_start), 32'(!reset && enable && m_slot == 0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int unsigned ch, input int unsigned val);
        wr_valid   = 1'b1;
        wr_channel = CW'(ch);
        wr_value   = VB'(val);
        tick();
        wr_valid   = 1'b0;
    endtask

    task automatic wait_frame();
        int unsigned n;
        n = 0;
        do begin
            tick();
            n++;
        end while (frame_start !== 1'b1 && n < 64);
        if (frame_start !== 1'b1) check("frame_timeout", 32'(frame_start), 32'd1);
    endtask

    int unsigned cnt [CH];
    int unsigned ones;
    logic [CH-1:0] pv;
    logic [CW-1:0] sv;

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        cmp_en     = 1'b0;
        reset      = 1'b1;
        enable     = 1'b1;
        wr_valid   = 1'b0;
        wr_channel = '0;
        wr_value   = '0;

        // Reset state
        tick();
        cmp_en = 1'b1;
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_pdm", 32'(pdm_out), 32'd0);
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_err", 32'(wr_error), 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_ready", 32'(wr_ready), 32'd1);
        check("post_rst_fs", 32'(frame_start), 32'd1);

        // Density, alternation and last-write-wins (ch0: 10 then 1, the 1 via bypass)
        do_write(0, 10);
        do_write(1, 128);
        do_write(2, 255);
        do_write(3, 0);
        do_write(0, 1);
        check("frame_after_writes", 32'(frame_start), 32'd1);
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int k = 0; k < 256; k++) begin
            wait_frame();
            pv = pdm_out;
            for (int c = 0; c < CH; c++) cnt[c] += 32'(pv[c]);
            if (k < 8) check("ch1_alternate", 32'(pv[1]), 32'(k % 2));
        end
        check("density_ch0", cnt[0], 32'd1);
        check("density_ch1", cnt[1], 32'd128);
        check("density_ch2", cnt[2], 32'd255);
        check("density_ch3", cnt[3], 32'd0);
        check("density_ch4", cnt[4], 32'd0);

        // Write in the last slot commits in the same frame
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        repeat (CH - 1) tick();
        check("bypass_slot", 32'(slot), 32'(CH - 1));
        do_write(0, 64);
        ones = 0;
        for (int k = 0; k < 4; k++) begin
            wait_frame();
            pv = pdm_out;
            ones += 32'(pv[0]);
        end
        check("bypass_ones", ones, 32'd1);

        // Out-of-range channels
        do_write(5, 77);
        check("err_pulse_5", 32'(wr_error), 32'd1);
        tick();
        check("err_clear", 32'(wr_error), 32'd0);
        do_write(7, 3);
        check("err_pulse_7", 32'(wr_error), 32'd1);
        do_write(2, 9);
        check("err_valid_ch", 32'(wr_error), 32'd0);

        // Freeze mid-frame with a write during the freeze
        wait_frame();
        tick();
        tick();
        enable = 1'b0;
        #1;
        sv = slot;
        pv = pdm_out;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) do_write(3, 200);
            else tick();
            check("freeze_slot", 32'(slot), 32'(sv));
            check("freeze_pdm", 32'(pdm_out), 32'(pv));
            check("freeze_fs", 32'(frame_start), 32'd0);
        end
        enable = 1'b1;
        tick();
        check("resume_slot", 32'(slot), 32'(sv) + 32'd1);
        repeat (3 * CH) tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            enable     = ($urandom_range(0, 9) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            wr_valid   = ($urandom_range(0, 2) == 0);
            wr_channel = CW'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       wr_value = '0;
                1:       wr_value = '1;
                default: wr_value = VB'($urandom);
            endcase
            tick();
        end
        reset    = 1'b0;
        enable   = 1'b1;
        wr_valid = 1'b0;
        repeat (2 * CH) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
